// File: rtl/ctrl_pkg.sv
// Shared constants for the ctrl_unit slice: opcodes, ALU source codes,
// active-low load masks and FSM state encodings.
// Optional feature macro: CTRL_UNIT_HALT_EN (adds HLT opcode and HALTED state).
package ctrl_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned LOAD_W  = 4;
  localparam int unsigned STATE_W = 2;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_ADD_A_IM = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_MOV_A_B  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_IN_A     = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_MOV_A_IM = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_MOV_B_A  = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_ADD_B_IM = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_IN_B     = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_MOV_B_IM = 4'b0111;
  localparam logic [OPC_W-1:0] OPC_OUT_B    = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_OUT_IM   = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_JNC      = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_JMP      = 4'b1111;
`ifdef CTRL_UNIT_HALT_EN
  localparam logic [OPC_W-1:0] OPC_HLT      = 4'b1000;
`endif

  // ALU source select
  localparam logic [SEL_W-1:0] SEL_A    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B    = 2'b10;
  localparam logic [SEL_W-1:0] SEL_IN   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'b11;

  // Active-low load enables {pc, out, b, a}
  localparam logic [LOAD_W-1:0] LOAD_A    = 4'b1110;
  localparam logic [LOAD_W-1:0] LOAD_B    = 4'b1101;
  localparam logic [LOAD_W-1:0] LOAD_OUT  = 4'b1011;
  localparam logic [LOAD_W-1:0] LOAD_PC   = 4'b0111;
  localparam logic [LOAD_W-1:0] LOAD_NONE = 4'b1111;

  // FSM states
  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_EXEC = 2'b01;
`ifdef CTRL_UNIT_HALT_EN
  localparam logic [STATE_W-1:0] ST_HALT = 2'b10;
`endif

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/carry_flag to sel/load/illegal decode table.
// Optional feature macro: CTRL_UNIT_HALT_EN (decodes 1000 as HLT).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic              carry_flag,
  output logic [SEL_W-1:0]  sel,
  output logic [LOAD_W-1:0] load,
  output logic              illegal
`ifdef CTRL_UNIT_HALT_EN
  ,
  output logic              hlt
`endif
);

  // Decode table; anything unlisted is a no-op flagged illegal
  always_comb begin
    sel     = SEL_ZERO;
    load    = LOAD_NONE;
    illegal = 1'b0;
`ifdef CTRL_UNIT_HALT_EN
    hlt     = 1'b0;
`endif
    unique case (opcode)
      OPC_MOV_A_IM: begin sel = SEL_ZERO; load = LOAD_A;   end
      OPC_MOV_B_IM: begin sel = SEL_ZERO; load = LOAD_B;   end
      OPC_MOV_A_B:  begin sel = SEL_B;    load = LOAD_A;   end
      OPC_MOV_B_A:  begin sel = SEL_A;    load = LOAD_B;   end
      OPC_ADD_A_IM: begin sel = SEL_A;    load = LOAD_A;   end
      OPC_ADD_B_IM: begin sel = SEL_B;    load = LOAD_B;   end
      OPC_IN_A:     begin sel = SEL_IN;   load = LOAD_A;   end
      OPC_IN_B:     begin sel = SEL_IN;   load = LOAD_B;   end
      OPC_OUT_IM:   begin sel = SEL_ZERO; load = LOAD_OUT; end
      OPC_OUT_B:    begin sel = SEL_B;    load = LOAD_OUT; end
      OPC_JMP:      begin sel = SEL_ZERO; load = LOAD_PC;  end
      OPC_JNC:      begin
        sel  = SEL_ZERO;
        load = carry_flag ? LOAD_NONE : LOAD_PC;
      end
`ifdef CTRL_UNIT_HALT_EN
      OPC_HLT:      hlt = 1'b1;
`endif
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Instruction sequencer: accepts {opcode, im} words, presents one decoded
// control word per instruction and tracks the carry flag.
// Optional feature macro: CTRL_UNIT_HALT_EN (HLT opcode, HALTED state, halted port).
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPC_W+DATA_W-1:0] op,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic                    alu_carry,
  input  logic                    ctl_ready,
  output logic                    ctl_valid,
  output logic [SEL_W-1:0]        sel,
  output logic [LOAD_W-1:0]       load,
  output logic [DATA_W-1:0]       im,
  output logic                    carry_flag,
  output logic                    illegal
`ifdef CTRL_UNIT_HALT_EN
  ,
  output logic                    halted
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               op_ready_d, ctl_valid_d, carry_d;
  logic [SEL_W-1:0]   sel_d;
  logic [LOAD_W-1:0]  load_d;
  logic [DATA_W-1:0]  im_d;
  logic               ill_q, ill_d;
  logic [SEL_W-1:0]   dec_sel;
  logic [LOAD_W-1:0]  dec_load;
  logic               dec_illegal;
`ifdef CTRL_UNIT_HALT_EN
  logic               hlt_q, hlt_d, halted_d, dec_hlt;
`endif

  // Decode the incoming word so the control word is registered at acceptance
  ctrl_decode u_decode (
    .opcode     (op[OPC_W+DATA_W-1 -: OPC_W]),
    .carry_flag (carry_flag),
    .sel        (dec_sel),
    .load       (dec_load),
    .illegal    (dec_illegal)
`ifdef CTRL_UNIT_HALT_EN
    ,
    .hlt        (dec_hlt)
`endif
  );

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    op_ready_d  = 1'b0;
    ctl_valid_d = 1'b0;
    sel_d       = SEL_ZERO;
    load_d      = LOAD_NONE;
    im_d        = '0;
    carry_d     = carry_flag;
    ill_d       = ill_q;
`ifdef CTRL_UNIT_HALT_EN
    hlt_d       = hlt_q;
    halted_d    = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid && op_ready) begin
          state_d     = ST_EXEC;
          ctl_valid_d = 1'b1;
          sel_d       = dec_sel;
          load_d      = dec_load;
          im_d        = op[DATA_W-1:0];
          ill_d       = dec_illegal;
`ifdef CTRL_UNIT_HALT_EN
          hlt_d       = dec_hlt;
`endif
        end else begin
          op_ready_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (ctl_ready) begin
          carry_d = alu_carry;
`ifdef CTRL_UNIT_HALT_EN
          if (hlt_q) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else
`endif
          begin
            state_d    = ST_IDLE;
            op_ready_d = 1'b1;
          end
        end else begin
          ctl_valid_d = 1'b1;
          sel_d       = sel;
          load_d      = load;
          im_d        = im;
        end
      end
`ifdef CTRL_UNIT_HALT_EN
      ST_HALT: halted_d = 1'b1;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pre-decoded instruction register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_ready   <= 1'b0;
      ctl_valid  <= 1'b0;
      sel        <= SEL_ZERO;
      load       <= LOAD_NONE;
      im         <= '0;
      carry_flag <= 1'b0;
      ill_q      <= 1'b0;
`ifdef CTRL_UNIT_HALT_EN
      hlt_q      <= 1'b0;
      halted     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_ready   <= op_ready_d;
      ctl_valid  <= ctl_valid_d;
      sel        <= sel_d;
      load       <= load_d;
      im         <= im_d;
      carry_flag <= carry_d;
      ill_q      <= ill_d;
`ifdef CTRL_UNIT_HALT_EN
      hlt_q      <= hlt_d;
      halted     <= halted_d;
`endif
    end
  end

  // Illegal pulse coincides with the completing cycle, so it is combinational
  assign illegal = (state_q == ST_EXEC) && ctl_ready && ill_q && !rst;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed scenarios then random traffic,
// compared against a transaction-level model built from the decode table.
module tb_ctrl_unit;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    op = 8'h00;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic          alu_carry = 1'b0;
  logic          ctl_ready = 1'b0;
  logic          ctl_valid;
  logic [1:0]    sel;
  logic [3:0]    load;
  logic [DW-1:0] im;
  logic          carry_flag;
  logic          illegal;
`ifdef CTRL_UNIT_HALT_EN
  logic          halted;
`endif

  ctrl_unit #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .alu_carry  (alu_carry),
    .ctl_ready  (ctl_ready),
    .ctl_valid  (ctl_valid),
    .sel        (sel),
    .load       (load),
    .im         (im),
    .carry_flag (carry_flag),
    .illegal    (illegal)
`ifdef CTRL_UNIT_HALT_EN
    ,
    .halted     (halted)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 idle, 1 executing, 2 halted
  int         phase = 0;
  bit         m_fresh = 1'b1;
  bit         m_carry = 1'b0;
  logic [7:0] m_word = 8'h00;
  bit [1:0]   tab_sel  [16];
  bit [3:0]   tab_load [16];
  bit         tab_ill  [16];
  bit         tab_hlt  [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input int opc, input bit [1:0] s, input bit [3:0] l);
    tab_sel[opc]  = s;
    tab_load[opc] = l;
    tab_ill[opc]  = 1'b0;
  endtask

  function automatic logic [3:0] exp_load();
    logic [3:0] opc;
    opc = m_word[7:4];
    if (phase != 1) return 4'hF;
    if (opc == 4'hE) return m_carry ? 4'hF : 4'h7;
    return tab_load[opc];
  endfunction

  // One clock: drive, check the combinational pulse, clock, update model, check registers
  task automatic step(input logic r, input logic v, input logic [7:0] w,
                      input logic cr, input logic ac);
    rst = r; op_valid = v; op = w; ctl_ready = cr; alu_carry = ac;
    #1;
    check("illegal", illegal, 32'(!r && phase == 1 && cr && tab_ill[m_word[7:4]]));
    @(posedge clk);
    if (r) begin
      phase = 0; m_carry = 1'b0; m_fresh = 1'b1;
    end else begin
      case (phase)
        0: if (v && !m_fresh) begin phase = 1; m_word = w; end
        1: if (cr) begin m_carry = ac; phase = tab_hlt[m_word[7:4]] ? 2 : 0; end
        default: ;
      endcase
      m_fresh = 1'b0;
    end
    #1;
    check("op_ready",   op_ready,   32'(phase == 0 && !m_fresh));
    check("ctl_valid",  ctl_valid,  32'(phase == 1));
    check("sel",        sel,        32'((phase == 1) ? tab_sel[m_word[7:4]] : 2'b11));
    check("load",       load,       32'(exp_load()));
    check("im",         im,         32'((phase == 1) ? m_word[3:0] : 4'h0));
    check("carry_flag", carry_flag, 32'(m_carry));
`ifdef CTRL_UNIT_HALT_EN
    check("halted",     halted,     32'(phase == 2));
`endif
  endtask

  // Issue one instruction from idle, stall it, then complete with the given carry
  task automatic issue(input logic [7:0] w, input int stall, input logic ac,
                       input logic [1:0] es, input logic [3:0] el, input string tag);
    for (int i = 0; i < 4 && !(phase == 0 && !m_fresh); i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, w, 1'b1, 1'b0);
    check({tag, "_valid"}, ctl_valid, 32'd1);
    check({tag, "_sel"}, sel, 32'(es));
    check({tag, "_load"}, load, 32'(el));
    for (int i = 0; i < stall; i++) step(1'b0, 1'b1, w, 1'b0, ac);
    step(1'b0, 1'b1, 8'h00, 1'b1, ac);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tab_sel[i] = 2'b11; tab_load[i] = 4'hF; tab_ill[i] = 1'b1; tab_hlt[i] = 1'b0;
    end
    set_op(4'b0011, 2'b11, 4'b1110);
    set_op(4'b0111, 2'b11, 4'b1101);
    set_op(4'b0001, 2'b10, 4'b1110);
    set_op(4'b0100, 2'b00, 4'b1101);
    set_op(4'b0000, 2'b00, 4'b1110);
    set_op(4'b0101, 2'b10, 4'b1101);
    set_op(4'b0010, 2'b01, 4'b1110);
    set_op(4'b0110, 2'b01, 4'b1101);
    set_op(4'b1011, 2'b11, 4'b1011);
    set_op(4'b1001, 2'b10, 4'b1011);
    set_op(4'b1111, 2'b11, 4'b0111);
    set_op(4'b1110, 2'b11, 4'b1111);
`ifdef CTRL_UNIT_HALT_EN
    tab_ill[8] = 1'b0;
    tab_hlt[8] = 1'b1;
`endif

    // Reset and first ready cycle
    step(1'b1, 1'b1, 8'h35, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_op_ready", op_ready, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_op_ready", op_ready, 32'd1);

    issue(8'h35, 0, 1'b0, 2'b11, 4'b1110, "mov_a_5");
    issue(8'h02, 0, 1'b1, 2'b00, 4'b1110, "add_a_c1");
    issue(8'hE3, 0, 1'b0, 2'b11, 4'b1111, "jnc_c1");
    issue(8'h02, 0, 1'b0, 2'b00, 4'b1110, "add_a_c0");
    issue(8'hE3, 0, 1'b0, 2'b11, 4'b0111, "jnc_c0");
    issue(8'h90, 3, 1'b0, 2'b10, 4'b1011, "out_b_stall");
    issue(8'hA0, 0, 1'b1, 2'b11, 4'b1111, "undef_op");

    // Reset during JMP execution
    for (int i = 0; i < 4 && !(phase == 0 && !m_fresh); i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hF7, 1'b0, 1'b0);
    check("jmp_load", load, 32'h7);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("jmp_rst_load", load, 32'hF);
    check("jmp_rst_valid", ctl_valid, 32'd0);
    check("jmp_rst_carry", carry_flag, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Opcode 1000: HLT when enabled, otherwise illegal
    issue(8'h80, 0, 1'b0, 2'b11, 4'b1111, "op_1000");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h35, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 63) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 4: immediate and data width, range 4..16.
REQ-003 Parameter OPC_W, fixed at 4: opcode width; the instruction word width is OPC_W+DATA_W.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 op  in  OPC_W+DATA_W  instruction word {opcode, im}.
REQ-007 op_valid  in  1  instruction word present.
REQ-008 op_ready  out  1  block can accept an instruction.
REQ-009 alu_carry  in  1  ALU carry-out of the instruction currently in EXEC.
REQ-010 ctl_ready  in  1  datapath accepts the current control word.
REQ-011 ctl_valid  out  1  sel, load and im are valid.
REQ-012 sel  out  2  ALU source: 00 reg A, 10 reg B, 01 input port, 11 zero.
REQ-013 load  out  4  active-low load enables {pc, out, b, a}.
REQ-014 im  out  DATA_W  immediate field of the executing instruction.
REQ-015 carry_flag  out  1  registered carry flag.
REQ-016 illegal  out  1  one-cycle pulse when an undefined opcode completes.

Function
REQ-017 States SHALL be IDLE, EXEC and, when the feature in REQ-033 is compiled in, HALTED.
REQ-018 op_ready SHALL be 1 only in IDLE; a transfer occurs when op_valid and op_ready are both high; the word is captured into an instruction register and the state moves to EXEC.
REQ-019 In EXEC, ctl_valid=1 and sel, load and im SHALL be decoded from the instruction register and carry_flag, with latency of 1 cycle from the accepting edge.
REQ-020 EXEC SHALL hold with outputs stable while ctl_ready=0; when ctl_ready=1, the block returns to IDLE at the next edge, so the best-case throughput is 1 instruction per 2 cycles.
REQ-021 Decode table (opcode: sel, load) SHALL be:
- 0011 MOV A,Im: 11, 1110
- 0111 MOV B,Im: 11, 1101
- 0001 MOV A,B: 10, 1110
- 0100 MOV B,A: 00, 1101
- 0000 ADD A,Im: 00, 1110
- 0101 ADD B,Im: 10, 1101
- 0010 IN A: 01, 1110
- 0110 IN B: 01, 1101
- 1011 OUT Im: 11, 1011
- 1001 OUT B: 10, 1011
- 1111 JMP: 11, 0111
REQ-022 For JNC (1110), the outputs SHALL be sel=11 with load=0111 when carry_flag=0, and sel=11 with load=1111 (no-op, PC increments) when carry_flag=1.
REQ-023 Every other opcode SHALL produce sel=11 and load=1111, and illegal SHALL pulse on the EXEC completion cycle.
REQ-024 On each EXEC completion (ctl_ready=1), carry_flag SHALL be updated to alu_carry for every opcode, JMP and JNC included.
REQ-025 Outside EXEC, the outputs SHALL be sel=11, load=1111, ctl_valid=0 and im=0; X SHALL never be driven.
REQ-026 When EXEC completes, any op_valid present is ignored until op_ready is asserted in the following IDLE cycle.

Reset
REQ-027 While rst=1, the state SHALL be IDLE with op_ready=0, ctl_valid=0, sel=11, load=1111, im=0, carry_flag=0 and illegal=0.
REQ-028 op_ready SHALL assert on the first cycle after rst is deasserted.
REQ-029 Reset asserted in EXEC or HALTED SHALL abort the instruction without a completion, and carry_flag SHALL be unchanged by alu_carry.

Configuration
REQ-030 Macro CTRL_UNIT_HALT_EN SHALL enable opcode 1000 as HLT.
REQ-031 With CTRL_UNIT_HALT_EN defined, completing 1000 in EXEC SHALL produce load=1111 and move to HALTED, where op_ready=0 and ctl_valid=0 until rst.
REQ-032 Without CTRL_UNIT_HALT_EN, opcode 1000 SHALL be illegal per REQ-023 and the HALTED state SHALL not exist.
REQ-033 The halted output SHALL exist only when CTRL_UNIT_HALT_EN is defined: out, 1 bit, high in HALTED.

Structure
REQ-034 Package ctrl_pkg SHALL hold the opcode constants, sel codes, load masks and the state enumeration.
REQ-035 Sub-module ctrl_decode SHALL hold the combinational opcode/carry_flag to sel/load/illegal table.
REQ-036 ctrl_unit SHALL hold the FSM, the instruction register and carry_flag.

Verification
REQ-037 Reset then op=0x35 (MOV A,5) with op_valid=1 and ctl_ready=1 -> the next cycle shows ctl_valid=1, sel=11, load=1110, im=5, followed by IDLE.
REQ-038 Send ADD A,Im with alu_carry=1, then JNC 0x3 -> JNC shows load=1111; repeat with alu_carry=0 -> load=0111, im=3.
REQ-039 With ctl_ready held at 0 for 3 cycles during OUT B -> sel=10 and load=1011 stay stable for 4 cycles, and op_ready stays 0.
REQ-040 Send opcode 1010 -> sel=11, load=1111, and illegal pulses for exactly 1 cycle.
REQ-041 Assert rst during EXEC of JMP -> the next cycle shows load=1111, ctl_valid=0 and carry_flag=0.
REQ-042 With CTRL_UNIT_HALT_EN, send 0x80 -> halted=1 and op_ready stays 0 until rst; without the macro -> illegal pulses and op_ready returns to 1.
